// File: rtl/agc_mode_controller.sv
// AGC loop sequencer: measures the I/Q output amplitude against the reference level and selects
// acquisition or tracking coefficients, with lock/unlock detection, hold and acquisition timeout.
module agc_mode_controller #(
    parameter int                     W_IN_MODULE = 26,
    parameter int                     FILTERWIDTH = 13,
    parameter int                     RWIDTH      = 8,
    parameter int                     CNTWIDTH    = 16,
    parameter int                     TOL_SHIFT   = 3,
    parameter int                     LOCK_CNT    = 64,
    parameter int                     UNLOCK_CNT  = 16,
    parameter int                     ACQ_TIMEOUT = 4096,
    parameter logic [FILTERWIDTH-1:0] ACQ_FILT    = 13'h0800,
    parameter logic [FILTERWIDTH-1:0] ACQ_ERR     = 13'h0400,
    parameter logic [FILTERWIDTH-1:0] TRK_FILT    = 13'h0100,
    parameter logic [FILTERWIDTH-1:0] TRK_ERR     = 13'h0040,
    parameter logic [RWIDTH-1:0]      R_DEFAULT   = 8'h40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_wr,
    input  logic [2:0]                    cfg_addr,
    input  logic [15:0]                   cfg_data,
    input  logic                          hold,
    input  logic                          Valid_In,
    input  logic signed [W_IN_MODULE-1:0] InputI,
    input  logic signed [W_IN_MODULE-1:0] InputQ,
    output logic [FILTERWIDTH-1:0]        Filter_Coefficient,
    output logic [FILTERWIDTH-1:0]        Error_Coefficient,
    output logic [RWIDTH-1:0]             R_level,
    output logic [1:0]                    state,
    output logic                          locked,
    output logic                          acq_timeout
);

    localparam int W  = W_IN_MODULE;
    localparam int WA = W - 1;
    localparam int WT = W + 2;
    localparam logic [CNTWIDTH-1:0] CNT_ONE     = CNTWIDTH'(1);
    localparam logic [CNTWIDTH-1:0] LOCK_LAST   = CNTWIDTH'(LOCK_CNT - 1);
    localparam logic [CNTWIDTH-1:0] UNLOCK_LAST = CNTWIDTH'(UNLOCK_CNT - 1);
    localparam logic [CNTWIDTH-1:0] ACQ_LAST    = CNTWIDTH'(ACQ_TIMEOUT - 1);
    localparam logic [CNTWIDTH-1:0] ACQ_SAT     = CNTWIDTH'(ACQ_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    held_trk_q, held_trk_d;
    logic [CNTWIDTH-1:0]     lock_cnt_q, lock_cnt_d;
    logic [CNTWIDTH-1:0]     unlock_cnt_q, unlock_cnt_d;
    logic [CNTWIDTH-1:0]     acq_cnt_q, acq_cnt_d;
    logic                    acq_timeout_q, acq_timeout_d;
    logic                    enable_q, enable_d;
    logic [FILTERWIDTH-1:0]  acq_filt_q, acq_filt_d, acq_err_q, acq_err_d;
    logic [FILTERWIDTH-1:0]  trk_filt_q, trk_filt_d, trk_err_q, trk_err_d;
    logic [RWIDTH-1:0]       r_cfg_q, r_cfg_d;
    logic [FILTERWIDTH-1:0]  filt_q, filt_d, err_q, err_d;
    logic [RWIDTH-1:0]       r_out_q, r_out_d;
    logic                    s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [W-1:0]            s0_i_q, s0_i_d, s0_q_q, s0_q_d;
    logic [WA-1:0]           s1_abs_i_q, s1_abs_i_d, s1_abs_q_q, s1_abs_q_d;
    logic                    s2_in_win_q, s2_in_win_d;
    logic [WA-1:0]           mag_max, mag_min;
    logic [WT-1:0]           mag, target, diff, tol;
    logic                    win_now;
    logic                    clear_cnt, timeout_set, clear_timeout;
    logic                    unused_cfg;

    assign unused_cfg = ^cfg_data[15:FILTERWIDTH];

    // The most negative input has no positive twin in W bits, so it saturates to the largest magnitude.
    function automatic logic [WA-1:0] abs_sat(input logic [W-1:0] x);
        logic [W-1:0] neg;
        neg = -x;
        if (!x[W-1])        abs_sat = x[WA-1:0];
        else if (neg[W-1])  abs_sat = '1;
        else                abs_sat = neg[WA-1:0];
    endfunction

    always_comb begin
        enable_d   = enable_q;
        acq_filt_d = acq_filt_q;
        acq_err_d  = acq_err_q;
        trk_filt_d = trk_filt_q;
        trk_err_d  = trk_err_q;
        r_cfg_d    = r_cfg_q;
        if (cfg_wr) begin
            case (cfg_addr)
                3'd0:    acq_filt_d = cfg_data[FILTERWIDTH-1:0];
                3'd1:    acq_err_d  = cfg_data[FILTERWIDTH-1:0];
                3'd2:    trk_filt_d = cfg_data[FILTERWIDTH-1:0];
                3'd3:    trk_err_d  = cfg_data[FILTERWIDTH-1:0];
                3'd4:    r_cfg_d    = cfg_data[RWIDTH-1:0];
                3'd5:    enable_d   = cfg_data[0];
                default: ;
            endcase
        end
        clear_timeout = cfg_wr && (cfg_addr == 3'd5) && cfg_data[1];
    end

    // Valid_In qualifies InputI/InputQ in the same cycle; there is no back-pressure. The valid bits
    // shift every cycle while the data registers only load on a qualified sample.
    always_comb begin
        s0_valid_d  = Valid_In;
        s0_i_d      = Valid_In ? InputI : s0_i_q;
        s0_q_d      = Valid_In ? InputQ : s0_q_q;
        s1_valid_d  = s0_valid_q;
        s1_abs_i_d  = s0_valid_q ? abs_sat(s0_i_q) : s1_abs_i_q;
        s1_abs_q_d  = s0_valid_q ? abs_sat(s0_q_q) : s1_abs_q_q;

        if (s1_abs_i_q >= s1_abs_q_q) begin
            mag_max = s1_abs_i_q;
            mag_min = s1_abs_q_q;
        end else begin
            mag_max = s1_abs_q_q;
            mag_min = s1_abs_i_q;
        end
        mag     = WT'(mag_max) + WT'(mag_min >> 1);
        target  = WT'({r_out_q, 12'b0});
        diff    = (mag >= target) ? (mag - target) : (target - mag);
        tol     = target >> TOL_SHIFT;
        win_now = (diff <= tol);

        s2_valid_d  = s1_valid_q;
        s2_in_win_d = s1_valid_q ? win_now : s2_in_win_q;
    end

    always_comb begin
        state_d      = state_q;
        held_trk_d   = held_trk_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        acq_cnt_d    = acq_cnt_q;
        clear_cnt    = 1'b0;
        timeout_set  = 1'b0;
        if (!enable_q) begin
            state_d   = ST_IDLE;
            clear_cnt = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ACQUIRE;
                    clear_cnt = 1'b1;
                end
                ST_ACQUIRE: begin
                    if (hold) begin
                        state_d    = ST_HOLD;
                        held_trk_d = 1'b0;
                        clear_cnt  = 1'b1;
                    end else if (s2_valid_q) begin
                        if (acq_cnt_q != ACQ_SAT) begin
                            acq_cnt_d   = acq_cnt_q + CNT_ONE;
                            timeout_set = (acq_cnt_q == ACQ_LAST);
                        end
                        if (!s2_in_win_q) begin
                            lock_cnt_d = '0;
                        end else if (lock_cnt_q == LOCK_LAST) begin
                            state_d   = ST_TRACK;
                            clear_cnt = 1'b1;
                        end else begin
                            lock_cnt_d = lock_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_TRACK: begin
                    if (hold) begin
                        state_d    = ST_HOLD;
                        held_trk_d = 1'b1;
                        clear_cnt  = 1'b1;
                    end else if (s2_valid_q) begin
                        if (s2_in_win_q) begin
                            unlock_cnt_d = '0;
                        end else if (unlock_cnt_q == UNLOCK_LAST) begin
                            state_d   = ST_ACQUIRE;
                            clear_cnt = 1'b1;
                        end else begin
                            unlock_cnt_d = unlock_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    clear_cnt = 1'b1;
                    if (!hold) begin
                        if (held_trk_q) state_d = ST_TRACK;
                        else            state_d = ST_ACQUIRE;
                    end
                end
            endcase
        end
        if (clear_cnt) begin
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            acq_cnt_d    = '0;
        end
        acq_timeout_d = acq_timeout_q;
        if (timeout_set)        acq_timeout_d = 1'b1;
        else if (clear_timeout) acq_timeout_d = 1'b0;
    end

    always_comb begin
        filt_d  = filt_q;
        err_d   = '0;
        r_out_d = r_cfg_q;
        case (state_q)
            ST_IDLE:    filt_d = acq_filt_q;
            ST_ACQUIRE: begin
                filt_d = acq_filt_q;
                err_d  = acq_err_q;
            end
            ST_TRACK:   begin
                filt_d = trk_filt_q;
                err_d  = trk_err_q;
            end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            held_trk_q    <= 1'b0;
            lock_cnt_q    <= '0;
            unlock_cnt_q  <= '0;
            acq_cnt_q     <= '0;
            acq_timeout_q <= 1'b0;
            enable_q      <= 1'b0;
            acq_filt_q    <= ACQ_FILT;
            acq_err_q     <= ACQ_ERR;
            trk_filt_q    <= TRK_FILT;
            trk_err_q     <= TRK_ERR;
            r_cfg_q       <= R_DEFAULT;
            filt_q        <= ACQ_FILT;
            err_q         <= '0;
            r_out_q       <= R_DEFAULT;
            s0_valid_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s0_i_q        <= '0;
            s0_q_q        <= '0;
            s1_abs_i_q    <= '0;
            s1_abs_q_q    <= '0;
            s2_in_win_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_trk_q    <= held_trk_d;
            lock_cnt_q    <= lock_cnt_d;
            unlock_cnt_q  <= unlock_cnt_d;
            acq_cnt_q     <= acq_cnt_d;
            acq_timeout_q <= acq_timeout_d;
            enable_q      <= enable_d;
            acq_filt_q    <= acq_filt_d;
            acq_err_q     <= acq_err_d;
            trk_filt_q    <= trk_filt_d;
            trk_err_q     <= trk_err_d;
            r_cfg_q       <= r_cfg_d;
            filt_q        <= filt_d;
            err_q         <= err_d;
            r_out_q       <= r_out_d;
            s0_valid_q    <= s0_valid_d;
            s1_valid_q    <= s1_valid_d;
            s2_valid_q    <= s2_valid_d;
            s0_i_q        <= s0_i_d;
            s0_q_q        <= s0_q_d;
            s1_abs_i_q    <= s1_abs_i_d;
            s1_abs_q_q    <= s1_abs_q_d;
            s2_in_win_q   <= s2_in_win_d;
        end
    end

    assign state              = state_q;
    assign locked             = (state_q == ST_TRACK);
    assign acq_timeout        = acq_timeout_q;
    assign Filter_Coefficient = filt_q;
    assign Error_Coefficient  = err_q;
    assign R_level            = r_out_q;

endmodule
